reg_hazard_ctrl: RTL and testbench

//  Issue/retire scoreboard and write-port sequencer for the 16x16-bit register file (2 read, 2 write ports E/M).

---
 rtl/reg_hazard_ctrl_pkg.sv | 16 +
 rtl/reg_hazard_ctrl_if.sv | 26 ++
 rtl/reg_hazard_ctrl_pending_cnt.sv | 29 ++
 rtl/reg_hazard_ctrl.sv | 50 +++++
 tb/tb_reg_hazard_ctrl.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/reg_hazard_ctrl_pkg.sv
// reg_ctrl_pkg: shared constants, register ids and helpers for the hazard controller
package reg_ctrl_pkg;
  localparam int NREGS = 16;
  localparam int ID_W = 5;
  localparam int CNT_W = 2;
  localparam int IDX_W = $clog2(NREGS);
  localparam logic [CNT_W-1:0] MAX_INFLIGHT = '1;
  localparam logic [ID_W-1:0] REG_NONE = 5'd15;
  typedef enum logic [ID_W-1:0] {
    RAX = 5'd0, RCX, RDX, RBX, RSP, RBP, RSI, RDI,
    R8, R9, R10, R11, R12, R13, R14
  } reg_id_e;
  function automatic logic is_none(input logic [ID_W-1:0] id);
    return id >= REG_NONE;
  endfunction
endpackage

// File: rtl/reg_hazard_ctrl_if.sv
// reg_hazard_ctrl_if: issue, writeback and register-file port bundle
interface reg_hazard_ctrl_if;
  import reg_ctrl_pkg::*;
  logic issue_valid;
  logic issue_ready;
  logic [ID_W-1:0] issue_srcA;
  logic [ID_W-1:0] issue_srcB;
  logic [ID_W-1:0] issue_dstE;
  logic [ID_W-1:0] issue_dstM;
  logic wb_valid;
  logic [ID_W-1:0] wb_dstE;
  logic [ID_W-1:0] wb_dstM;
  logic [ID_W-1:0] rf_dstE;
  logic [ID_W-1:0] rf_dstM;
  logic [NREGS-1:0] pending;
  logic [15:0] stall_cnt;
  logic err_underflow;
  modport master (
    output issue_valid, issue_srcA, issue_srcB, issue_dstE, issue_dstM, wb_valid, wb_dstE, wb_dstM,
    input issue_ready, rf_dstE, rf_dstM, pending, stall_cnt, err_underflow
  );
  modport slave (
    input issue_valid, issue_srcA, issue_srcB, issue_dstE, issue_dstM, wb_valid, wb_dstE, wb_dstM,
    output issue_ready, rf_dstE, rf_dstM, pending, stall_cnt, err_underflow
  );
endinterface

// File: rtl/reg_hazard_ctrl_pending_cnt.sv
// reg_pending_cnt: saturating in-flight write counter with underflow detect
module reg_pending_cnt
  import reg_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic [1:0] inc,
  input  logic [1:0] dec,
  output logic [CNT_W-1:0] cnt,
  output logic pend,
  output logic uf
);
  logic [CNT_W:0] sum, diff;
  logic [CNT_W-1:0] nxt;
  always_comb begin
    sum = {1'b0, cnt} + (CNT_W+1)'(inc);
    uf = (CNT_W+1)'(dec) > sum;
    diff = uf ? '0 : sum - (CNT_W+1)'(dec);
    nxt = diff > {1'b0, MAX_INFLIGHT} ? MAX_INFLIGHT : diff[CNT_W-1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      pend <= 1'b0;
    end else begin
      cnt <= nxt;
      pend <= nxt != '0;
    end
endmodule

// File: rtl/reg_hazard_ctrl.sv
// reg_hazard_ctrl: issue/retire scoreboard and E/M write-port sequencer
module reg_hazard_ctrl
  import reg_ctrl_pkg::*;
(
  input logic clk,
  input logic rst_n,
  reg_hazard_ctrl_if.slave bus
);
  logic [CNT_W-1:0] cnt [NREGS];
  logic [NREGS-1:0] pend, uf;
  logic [CNT_W:0] need;
  logic raw_ok, room_e, room_m, ready, fired, wb_en;
  always_comb begin
    need = bus.issue_dstE == bus.issue_dstM ? (CNT_W+1)'(2) : (CNT_W+1)'(1);
    raw_ok = (is_none(bus.issue_srcA) || cnt[bus.issue_srcA[IDX_W-1:0]] == '0) &&
             (is_none(bus.issue_srcB) || cnt[bus.issue_srcB[IDX_W-1:0]] == '0);
    room_e = is_none(bus.issue_dstE) || {1'b0, cnt[bus.issue_dstE[IDX_W-1:0]]} + need <= {1'b0, MAX_INFLIGHT};
    room_m = is_none(bus.issue_dstM) || {1'b0, cnt[bus.issue_dstM[IDX_W-1:0]]} + need <= {1'b0, MAX_INFLIGHT};
    ready = raw_ok && room_e && room_m;
  end
  assign fired = bus.issue_valid && ready;
  assign wb_en = rst_n && bus.wb_valid;
  assign bus.issue_ready = ready;
  assign bus.pending = pend;
  assign bus.rf_dstM = wb_en && !is_none(bus.wb_dstM) ? bus.wb_dstM : REG_NONE;
  assign bus.rf_dstE = wb_en && !is_none(bus.wb_dstE) && bus.wb_dstE != bus.wb_dstM ? bus.wb_dstE : REG_NONE;
  for (genvar r = 0; r < NREGS; r++) begin : g_cnt
    localparam logic [ID_W-1:0] RID = ID_W'(r);
    logic [1:0] inc, dec;
    assign inc = fired && !is_none(RID) ? 2'(bus.issue_dstE == RID) + 2'(bus.issue_dstM == RID) : 2'd0;
    assign dec = bus.wb_valid && !is_none(RID) ? 2'(bus.wb_dstE == RID) + 2'(bus.wb_dstM == RID) : 2'd0;
    reg_pending_cnt u_cnt (
      .clk(clk),
      .rst_n(rst_n),
      .inc(inc),
      .dec(dec),
      .cnt(cnt[r]),
      .pend(pend[r]),
      .uf(uf[r])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.stall_cnt <= '0;
      bus.err_underflow <= 1'b0;
    end else begin
      if (bus.issue_valid && !ready && bus.stall_cnt != 16'hFFFF) bus.stall_cnt <= bus.stall_cnt + 16'd1;
      if (|uf) bus.err_underflow <= 1'b1;
    end
endmodule

// File: tb/tb_reg_hazard_ctrl.sv
// tb_reg_hazard_ctrl: directed self-checking bench for reg_hazard_ctrl
module tb_reg_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  localparam logic [4:0] N = 5'd15;
  reg_hazard_ctrl_if bus();
  reg_hazard_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic iv, input logic [4:0] sa, sb, de, dm, input logic wv, input logic [4:0] we, wm);
    bus.issue_valid = iv;
    bus.issue_srcA = sa;
    bus.issue_srcB = sb;
    bus.issue_dstE = de;
    bus.issue_dstM = dm;
    bus.wb_valid = wv;
    bus.wb_dstE = we;
    bus.wb_dstM = wm;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  initial begin
    drive(0, N, N, N, N, 1, 5'd3, 5'd4);
    chk("rst_rf_dstE", 32'(bus.rf_dstE), 32'd15);
    chk("rst_rf_dstM", 32'(bus.rf_dstM), 32'd15);
    tick();
    rst_n = 1'b1;
    drive(0, N, N, N, N, 0, N, N);
    chk("post_rst_pending", 32'(bus.pending), 32'h0);
    chk("post_rst_stall", 32'(bus.stall_cnt), 32'd0);
    chk("post_rst_err", 32'(bus.err_underflow), 32'd0);
    chk("post_rst_ready", 32'(bus.issue_ready), 32'd1);
    drive(1, N, N, 5'd3, N, 0, N, N);
    tick();
    tick();
    chk("cnt3_pending", 32'(bus.pending), 32'h0008);
    drive(0, N, N, N, N, 1, 5'd3, 5'd4);
    rst_n = 1'b0;
    #1;
    chk("midrst_rf_dstE", 32'(bus.rf_dstE), 32'd15);
    chk("midrst_rf_dstM", 32'(bus.rf_dstM), 32'd15);
    chk("midrst_pending", 32'(bus.pending), 32'h0);
    chk("midrst_stall", 32'(bus.stall_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    drive(1, 5'd3, N, N, N, 0, N, N);
    chk("midrst_cleared_ready", 32'(bus.issue_ready), 32'd1);
    tick();
    drive(1, N, N, 5'd2, N, 0, N, N);
    chk("raw_first_ready", 32'(bus.issue_ready), 32'd1);
    tick();
    chk("raw_pending2", 32'(bus.pending), 32'h0004);
    drive(1, 5'd2, N, N, N, 0, N, N);
    chk("raw_blocked", 32'(bus.issue_ready), 32'd0);
    drive(1, 5'd2, N, N, N, 1, 5'd2, N);
    chk("raw_same_cycle_wb", 32'(bus.issue_ready), 32'd0);
    chk("wb_rf_dstE", 32'(bus.rf_dstE), 32'd2);
    tick();
    drive(1, 5'd2, N, N, N, 0, N, N);
    chk("raw_unblocked", 32'(bus.issue_ready), 32'd1);
    chk("raw_stall1", 32'(bus.stall_cnt), 32'd1);
    chk("raw_pending_clear", 32'(bus.pending), 32'h0);
    tick();
    drive(1, N, N, 5'd5, N, 0, N, N);
    tick();
    tick();
    tick();
    chk("room_pending5", 32'(bus.pending), 32'h0020);
    chk("room_full", 32'(bus.issue_ready), 32'd0);
    tick();
    chk("room_stall2", 32'(bus.stall_cnt), 32'd2);
    drive(1, N, N, 5'd5, N, 1, 5'd5, N);
    chk("room_same_cycle_wb", 32'(bus.issue_ready), 32'd0);
    tick();
    drive(1, N, N, 5'd5, N, 0, N, N);
    chk("room_after_retire", 32'(bus.issue_ready), 32'd1);
    chk("room_stall3", 32'(bus.stall_cnt), 32'd3);
    tick();
    drive(0, N, N, N, N, 1, 5'd5, 5'd5);
    tick();
    drive(0, N, N, N, N, 1, 5'd5, N);
    tick();
    drive(0, N, N, N, N, 0, N, N);
    chk("room_drained", 32'(bus.pending), 32'h0);
    chk("room_no_uf", 32'(bus.err_underflow), 32'd0);
    drive(1, N, N, 5'd4, N, 0, N, N);
    tick();
    tick();
    drive(1, N, N, 5'd4, 5'd4, 0, N, N);
    chk("same_dst_cnt2_blocked", 32'(bus.issue_ready), 32'd0);
    drive(0, N, N, N, N, 1, 5'd4, N);
    tick();
    drive(1, N, N, 5'd4, 5'd4, 0, N, N);
    chk("same_dst_cnt1_ready", 32'(bus.issue_ready), 32'd1);
    tick();
    drive(0, N, N, 5'd4, N, 0, N, N);
    chk("same_dst_cnt3_full", 32'(bus.issue_ready), 32'd0);
    drive(0, N, N, N, N, 1, 5'd4, 5'd4);
    chk("collide_rf_dstE", 32'(bus.rf_dstE), 32'd15);
    chk("collide_rf_dstM", 32'(bus.rf_dstM), 32'd4);
    tick();
    drive(0, N, N, 5'd4, 5'd4, 0, N, N);
    chk("same_dst_cnt1_room", 32'(bus.issue_ready), 32'd1);
    chk("same_dst_pending", 32'(bus.pending), 32'h0010);
    drive(0, N, N, N, N, 1, 5'd4, N);
    tick();
    chk("same_dst_drained", 32'(bus.pending), 32'h0);
    drive(1, N, N, 5'd7, N, 0, N, N);
    tick();
    drive(1, N, N, 5'd7, N, 1, 5'd7, 5'd20);
    chk("net_rf_dstE", 32'(bus.rf_dstE), 32'd7);
    chk("net_rf_dstM_none", 32'(bus.rf_dstM), 32'd15);
    tick();
    drive(0, N, N, N, N, 0, N, N);
    chk("net_pending7", 32'(bus.pending), 32'h0080);
    drive(0, N, N, N, N, 1, 5'd7, N);
    tick();
    drive(0, N, N, N, N, 0, N, N);
    chk("net_cnt7_was1", 32'(bus.pending), 32'h0);
    chk("net_no_uf", 32'(bus.err_underflow), 32'd0);
    drive(0, N, N, N, N, 1, N, 5'd9);
    tick();
    drive(0, N, N, N, N, 0, N, N);
    chk("uf_flag", 32'(bus.err_underflow), 32'd1);
    chk("uf_pending", 32'(bus.pending), 32'h0);
    tick();
    chk("uf_sticky", 32'(bus.err_underflow), 32'd1);
    drive(1, N, N, 5'd10, N, 0, N, N);
    tick();
    drive(1, 5'd10, N, N, N, 0, N, N);
    chk("sat_blocked", 32'(bus.issue_ready), 32'd0);
    chk("sat_stall_start", 32'(bus.stall_cnt), 32'd3);
    repeat (65531) tick();
    chk("sat_fffe", 32'(bus.stall_cnt), 32'hFFFE);
    repeat (4469) tick();
    chk("sat_ffff", 32'(bus.stall_cnt), 32'hFFFF);
    chk("uf_still_sticky", 32'(bus.err_underflow), 32'd1);
    drive(0, N, N, N, N, 0, N, N);
    rst_n = 1'b0;
    #1;
    chk("final_rst_stall", 32'(bus.stall_cnt), 32'd0);
    chk("final_rst_err", 32'(bus.err_underflow), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
